// File: rtl/debug_pkg.sv
// Shared types for the debug trace buffer: default sizes, FSM state enum, trace entry.
// Latency: n/a (types only).
// Backpressure: n/a.
// Optional feature macro: TRACE_TIMESTAMP_EN adds an 8-bit step stamp to each entry.
package debug_pkg;

  localparam int DEPTH_DEF = 8;   // trace entries, power of two, 2..16
  localparam int EW_DEF    = 16;  // display width: {alu_byte, res_byte}

  typedef enum logic {
    LIVE   = 1'b0,
    BROWSE = 1'b1
  } trace_state_t;

  typedef struct packed {
    logic [7:0] alu;
    logic [7:0] res;
`ifdef TRACE_TIMESTAMP_EN
    logic [7:0] stamp;
`endif
  } trace_entry_t;

endpackage

// File: rtl/debug_trace_buffer_ram.sv
// trace_ram: DEPTH x trace_entry_t storage, one synchronous write port, one async read port.
// Latency: write lands on the clk edge; read is combinational from the array.
// Backpressure: none; a write is accepted every cycle we is high.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read). The array has no reset.
module trace_ram
  import debug_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  trace_entry_t               wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output trace_entry_t               rdata
);

  trace_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/debug_trace_buffer.sv
// Single-step trace history with a LIVE / BROWSE display pager for a 4-digit display.
// Latency: step is delayed one clk before capture; display outputs are registered (1 clk).
// Backpressure: none; when full the oldest entry is overwritten.
// Ports: clk, reset (async active-low), step/alu_in/res_in (capture), scroll, clear,
//        disp_val/disp_idx/browsing/disp_stamp (display), count (valid entries).
// Optional feature macro: TRACE_TIMESTAMP_EN (8-bit step stamp per entry on disp_stamp).
module debug_trace_buffer
  import debug_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int EW    = EW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step,
  input  logic [7:0]    alu_in,
  input  logic [7:0]    res_in,
  input  logic          scroll,
  input  logic          clear,
  output logic [EW-1:0] disp_val,
  output logic [3:0]    disp_idx,
  output logic [4:0]    count,
  output logic          browsing,
  output logic [7:0]    disp_stamp
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [4:0]      CNT_FULL = 5'(DEPTH);

  trace_state_t  state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] offset_q, offset_d;
  logic [4:0]    count_q, count_d;
  logic          step_dly_q, step_dly_d;
  logic [EW-1:0] disp_val_q, disp_val_d;
  logic [3:0]    disp_idx_q, disp_idx_d;
  logic          browsing_q, browsing_d;

  logic          wr_en;
  trace_entry_t  wr_entry;
  logic [AW-1:0] rd_addr;
  trace_entry_t  rd_entry;

`ifdef TRACE_TIMESTAMP_EN
  logic [7:0]    stamp_q, stamp_d;
  logic [7:0]    disp_stamp_q, disp_stamp_d;
`endif

  trace_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_addr),
    .rdata (rd_entry)
  );

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    offset_d   = offset_q;
    count_d    = count_q;
    // A step pulse arriving with clear is dropped too, so clear never leaves a
    // capture pending for the following cycle.
    step_dly_d = step & ~clear;
    wr_en      = 1'b0;
    wr_entry     = '0;
    wr_entry.alu = alu_in;
    wr_entry.res = res_in;
`ifdef TRACE_TIMESTAMP_EN
    // Entry carries the counter value before this write's increment.
    wr_entry.stamp = stamp_q;
    stamp_d        = stamp_q;
`endif

    if (clear) begin
      state_d  = LIVE;
      wr_ptr_d = '0;
      offset_d = '0;
      count_d  = '0;
`ifdef TRACE_TIMESTAMP_EN
      stamp_d  = '0;
`endif
    end else if (step_dly_q) begin
      wr_en    = 1'b1;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (count_q != CNT_FULL) begin
        count_d = count_q + 5'd1;
      end
`ifdef TRACE_TIMESTAMP_EN
      stamp_d  = stamp_q + 8'd1;
`endif
      // Keep the same entry on screen; once it is the one being overwritten, go LIVE.
      if (state_q == BROWSE) begin
        if (5'(offset_q) + 5'd1 == count_d) begin
          state_d  = LIVE;
          offset_d = '0;
        end else begin
          offset_d = offset_q + PTR_ONE;
        end
      end
    end else if (scroll) begin
      if (state_q == LIVE) begin
        if (count_q != 5'd0) begin
          state_d  = BROWSE;
          offset_d = '0;
        end
      end else if (5'(offset_q) + 5'd1 < count_q) begin
        offset_d = offset_q + PTR_ONE;
      end else begin
        state_d  = LIVE;
        offset_d = '0;
      end
    end

    // Display follows the next state so it changes on the same edge as the FSM.
    // The read address never equals the slot written this cycle (that case goes LIVE),
    // so the async read of the pre-write array is the right data.
    rd_addr    = wr_ptr_d - PTR_ONE - offset_d;
    browsing_d = (state_d == BROWSE);
    if (state_d == BROWSE) begin
      disp_val_d = EW'({rd_entry.alu, rd_entry.res});
      disp_idx_d = 4'(offset_d);
    end else begin
      disp_val_d = EW'({alu_in, res_in});
      disp_idx_d = 4'd0;
    end
`ifdef TRACE_TIMESTAMP_EN
    disp_stamp_d = (state_d == BROWSE) ? rd_entry.stamp : stamp_d;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= LIVE;
      wr_ptr_q     <= '0;
      offset_q     <= '0;
      count_q      <= '0;
      step_dly_q   <= 1'b0;
      disp_val_q   <= '0;
      disp_idx_q   <= '0;
      browsing_q   <= 1'b0;
`ifdef TRACE_TIMESTAMP_EN
      stamp_q      <= '0;
      disp_stamp_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      offset_q     <= offset_d;
      count_q      <= count_d;
      step_dly_q   <= step_dly_d;
      disp_val_q   <= disp_val_d;
      disp_idx_q   <= disp_idx_d;
      browsing_q   <= browsing_d;
`ifdef TRACE_TIMESTAMP_EN
      stamp_q      <= stamp_d;
      disp_stamp_q <= disp_stamp_d;
`endif
    end
  end

  assign disp_val = disp_val_q;
  assign disp_idx = disp_idx_q;
  assign count    = count_q;
  assign browsing = browsing_q;
`ifdef TRACE_TIMESTAMP_EN
  assign disp_stamp = disp_stamp_q;
`else
  assign disp_stamp = 8'd0;
`endif

endmodule

// File: doc/debug_trace_buffer.md
DEBUG_TRACE_BUFFER -- requirements
Module: debug_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 8, number of trace entries; power of two, 2..16.
REQ-002 Parameter EW, default 16, entry width: {alu_byte, res_byte}.
REQ-003 clk  input  1  system clock, same domain as display scan and pulse outputs.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 step  input  1  single-cycle pulse marking one processor single-step.
REQ-006 alu_in  input  8  low byte of processor ALU result.
REQ-007 res_in  input  8  low byte of processor writeback result.
REQ-008 scroll  input  1  single-cycle pulse that pages to the next-older entry.
REQ-009 clear  input  1  single-cycle pulse that empties the buffer.
REQ-010 disp_val  output  16  value for the 4-digit display: {alu, res}.
REQ-011 disp_idx  output  4  history offset shown (0 = newest); 0 in LIVE.
REQ-012 count  output  5  valid entries, 0..DEPTH.
REQ-013 browsing  output  1  high in BROWSE state (drives the decimal point).
REQ-014 disp_stamp  output  8  step number of the shown entry (see Configuration).

Function
REQ-015 Capture: the block SHALL register step into step_d and write {alu_in,res_in} at wr_ptr in the cycle step_d is high, one clk after step, so the inputs have settled.
REQ-016 After a write, wr_ptr SHALL increment modulo DEPTH, and count SHALL increment, saturating at DEPTH.
REQ-017 When full, a write SHALL overwrite the oldest entry, and count SHALL stay at DEPTH.
REQ-018 FSM states SHALL be LIVE and BROWSE, with reset state LIVE.
REQ-019 In LIVE, disp_val SHALL equal {alu_in,res_in}, registered one cycle, and disp_idx SHALL be 0.
REQ-020 A scroll in LIVE with count>0 SHALL enter BROWSE at offset 0; with count=0 it SHALL be ignored.
REQ-021 In BROWSE, disp_val SHALL show entry (wr_ptr-1-offset) mod DEPTH, registered, one cycle after any change.
REQ-022 A scroll in BROWSE with offset<count-1 SHALL increment offset; with offset=count-1 it SHALL return to LIVE, offset 0.
REQ-023 A write in BROWSE SHALL increment offset so the same entry stays displayed.
REQ-024 If that increment would reach count (shown entry overwritten), the FSM SHALL return to LIVE instead.
REQ-025 clear SHALL set count=0, wr_ptr=0, offset=0 and state LIVE next cycle; entry contents need not be zeroed.
REQ-026 Priority: clear SHALL beat step_d, which SHALL beat scroll. If a scroll and a write coincide, the write applies (REQ-023/024) and the scroll is dropped.

Reset
REQ-027 Reset low SHALL asynchronously force state LIVE, wr_ptr=0, count=0, offset=0, step_d=0, disp_val=0, disp_idx=0, browsing=0, disp_stamp=0.
REQ-028 Release SHALL be synchronous to clk; no capture or scroll SHALL occur in the release cycle.
REQ-029 Reset mid-BROWSE SHALL discard all history.

Configuration
REQ-030 With TRACE_TIMESTAMP_EN defined, the block SHALL keep an 8-bit step counter (reset 0, +1 per write, wraps 255->0, cleared by clear).
REQ-031 With TRACE_TIMESTAMP_EN defined, the counter value SHALL be stored with each entry and shown on disp_stamp; in LIVE, disp_stamp SHALL show the current counter.
REQ-032 Without TRACE_TIMESTAMP_EN, no counter or stamp storage SHALL exist, and disp_stamp SHALL be tied to 0.

Structure
REQ-033 Shared package debug_pkg SHALL hold the DEPTH/EW defaults, the trace_state_t enum (LIVE, BROWSE) and the trace_entry_t struct (alu, res, optional stamp).
REQ-034 Storage SHALL be one sub-module, trace_ram: DEPTH x entry, one synchronous write port, one asynchronous read port, no reset on the array.

Verification
REQ-035 Reset, then 3 steps with (alu,res)=(11,22),(33,44),(55,66) -> count=3; 1 scroll -> disp_val=0x5566, idx=0, browsing=1.
REQ-036 From REQ-035 state, 2 more scrolls -> 0x1122, idx=2; a 3rd scroll -> LIVE, browsing=0, disp_val = current inputs.
REQ-037 10 steps with alu=i, res=i (i=1..10), DEPTH=8 -> count=8; 8 scrolls reach 0x0303; the 9th scroll returns to LIVE.
REQ-038 In BROWSE at idx=1 showing 0x3344, step with (77,88) -> idx=2, disp_val still 0x3344.
REQ-039 Full buffer in BROWSE at idx=7, then a step -> LIVE; clear with simultaneous step and scroll -> count=0, LIVE, no write.
REQ-040 With TRACE_TIMESTAMP_EN defined, 257 steps then 1 scroll -> disp_stamp=0x00 (the 257th step was stamped after one wrap); reset low mid-browse -> all outputs 0 immediately.
